// File: rtl/rs_custom_pkg.sv
// Shared widths, entry layout and wakeup helpers for the custom-unit reservation station.
// Width constants keep the names that constants.vh provided to the original code.
package rs_custom_pkg;

  localparam int DATA_LEN          = 32;
  localparam int RRF_SEL           = 6;
  localparam int SPECTAG_LEN       = 5;
  localparam int FUNCT3_WIDTH      = 3;
  localparam int FUNCT7_WIDTH      = 7;
  localparam int SRC_A_SEL_WIDTH   = 2;
  localparam int SRC_B_SEL_WIDTH   = 2;
  localparam int RS_CUSTOM_ENT_NUM = 4;
  localparam int RS_CUSTOM_ENT_SEL = 2;

  typedef logic [DATA_LEN-1:0]    data_t;
  typedef logic [RRF_SEL-1:0]     rrf_t;
  typedef logic [SPECTAG_LEN-1:0] spectag_t;

  typedef enum logic [1:0] {
    WK_NONE,
    WK_BUS0,
    WK_BUS1
  } wk_src_t;

  // While an operand is not valid, the low RRF_SEL bits of val hold the producer tag.
  typedef struct packed {
    logic  valid;
    data_t val;
  } rs_operand_t;

  typedef struct packed {
    rs_operand_t                op1;
    rs_operand_t                op2;
    data_t                      imm;
    rrf_t                       rrftag;
    logic                       dstval;
    logic [SRC_A_SEL_WIDTH-1:0] src_a;
    logic [SRC_B_SEL_WIDTH-1:0] src_b;
    logic [FUNCT7_WIDTH-1:0]    funct7;
    logic [FUNCT3_WIDTH-1:0]    funct3;
    spectag_t                   spectag;
    logic                       specbit;
  } rs_ent_t;

  function automatic logic spec_hit(spectag_t tag, spectag_t fix);
    return |(tag & fix);
  endfunction

  // Bus 0 has priority when both result buses carry the awaited tag.
  function automatic wk_src_t wake_src(rs_operand_t op, logic wb0_en, rrf_t wb0_tag,
                                       logic wb1_en, rrf_t wb1_tag);
    wk_src_t src;
    src = WK_NONE;
    if (!op.valid) begin
      if (wb0_en && (wb0_tag == op.val[RRF_SEL-1:0])) begin
        src = WK_BUS0;
      end else if (wb1_en && (wb1_tag == op.val[RRF_SEL-1:0])) begin
        src = WK_BUS1;
      end
    end
    return src;
  endfunction

  function automatic rs_operand_t capture(rs_operand_t op,
                                          logic wb0_en, rrf_t wb0_tag, data_t wb0_data,
                                          logic wb1_en, rrf_t wb1_tag, data_t wb1_data);
    rs_operand_t res;
    res = op;
    case (wake_src(op, wb0_en, wb0_tag, wb1_en, wb1_tag))
      WK_BUS0: begin
        res.valid = 1'b1;
        res.val   = wb0_data;
      end
      WK_BUS1: begin
        res.valid = 1'b1;
        res.val   = wb1_data;
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/prienc_rs.sv
// Lowest-index-wins priority encoder over the station entries.
module prienc_rs
  import rs_custom_pkg::*;
#(
  parameter int ENTRIES = RS_CUSTOM_ENT_NUM,
  parameter int ENT_SEL = RS_CUSTOM_ENT_SEL
) (
  input  logic [ENTRIES-1:0] req,
  output logic               en,
  output logic [ENT_SEL-1:0] idx
);

  always_comb begin
    en  = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (req[i] && !en) begin
        en  = 1'b1;
        idx = ENT_SEL'(i);
      end
    end
  end

endmodule

// File: rtl/rs_custom.sv
// Reservation station feeding exunit_custom: holds ops until both operands arrive,
// issues the lowest-index ready entry each cycle, and honours branch kill/clear.
module rs_custom
  import rs_custom_pkg::*;
#(
  parameter int ENTRIES = RS_CUSTOM_ENT_NUM,
  parameter int ENT_SEL = RS_CUSTOM_ENT_SEL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dp_we,
  input  logic [DATA_LEN-1:0]        dp_src1,
  input  logic                       dp_valid1,
  input  logic [DATA_LEN-1:0]        dp_src2,
  input  logic                       dp_valid2,
  input  logic [DATA_LEN-1:0]        dp_imm,
  input  logic [RRF_SEL-1:0]         dp_rrftag,
  input  logic                       dp_dstval,
  input  logic [SRC_A_SEL_WIDTH-1:0] dp_src_a,
  input  logic [SRC_B_SEL_WIDTH-1:0] dp_src_b,
  input  logic [FUNCT7_WIDTH-1:0]    dp_funct7,
  input  logic [FUNCT3_WIDTH-1:0]    dp_funct3,
  input  logic [SPECTAG_LEN-1:0]     dp_spectag,
  input  logic                       dp_specbit,
  input  logic                       wb0_en,
  input  logic [RRF_SEL-1:0]         wb0_tag,
  input  logic [DATA_LEN-1:0]        wb0_data,
  input  logic                       wb1_en,
  input  logic [RRF_SEL-1:0]         wb1_tag,
  input  logic [DATA_LEN-1:0]        wb1_data,
  input  logic                       prmiss,
  input  logic                       prsuccess,
  input  logic [SPECTAG_LEN-1:0]     spectagfix,
  output logic                       rs_full,
  output logic                       issue,
  output logic [DATA_LEN-1:0]        ex_src1,
  output logic [DATA_LEN-1:0]        ex_src2,
  output logic [DATA_LEN-1:0]        ex_imm,
  output logic [RRF_SEL-1:0]         ex_rrftag,
  output logic                       ex_dstval,
  output logic [SRC_A_SEL_WIDTH-1:0] ex_src_a,
  output logic [SRC_B_SEL_WIDTH-1:0] ex_src_b,
  output logic [FUNCT7_WIDTH-1:0]    ex_funct7,
  output logic [FUNCT3_WIDTH-1:0]    ex_funct3,
  output logic [SPECTAG_LEN-1:0]     ex_spectag,
  output logic                       ex_specbit
);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] busy_nx;
  logic [ENTRIES-1:0] kill;
  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] free_req;
  rs_ent_t            ent_q  [ENTRIES];
  rs_ent_t            ent_nx [ENTRIES];
  rs_ent_t            dp_ent;
  rs_ent_t            sel_ent;
  logic               alloc_en;
  logic               sel_en;
  logic [ENT_SEL-1:0] alloc_idx;
  logic [ENT_SEL-1:0] sel_idx;
  logic               clear_spec;
  logic               dp_kill;
  logic               dp_write;

  // A mispredict overrides a simultaneous correct-prediction report.
  assign clear_spec = prsuccess & ~prmiss;

  always_comb begin
    kill  = '0;
    ready = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      kill[i]  = prmiss & busy[i] & ent_q[i].specbit & spec_hit(ent_q[i].spectag, spectagfix);
      ready[i] = busy[i] & ent_q[i].op1.valid & ent_q[i].op2.valid & ~kill[i];
    end
  end

  assign free_req = ~busy;

  prienc_rs #(.ENTRIES(ENTRIES), .ENT_SEL(ENT_SEL)) u_alloc (
    .req (free_req),
    .en  (alloc_en),
    .idx (alloc_idx)
  );

  prienc_rs #(.ENTRIES(ENTRIES), .ENT_SEL(ENT_SEL)) u_select (
    .req (ready),
    .en  (sel_en),
    .idx (sel_idx)
  );

  assign rs_full = &busy;
  assign issue   = sel_en;

  // Dispatched operands may be satisfied by a result bus in the same cycle.
  always_comb begin
    dp_ent         = '0;
    dp_ent.op1     = capture(rs_operand_t'({dp_valid1, dp_src1}),
                             wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
    dp_ent.op2     = capture(rs_operand_t'({dp_valid2, dp_src2}),
                             wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
    dp_ent.imm     = dp_imm;
    dp_ent.rrftag  = dp_rrftag;
    dp_ent.dstval  = dp_dstval;
    dp_ent.src_a   = dp_src_a;
    dp_ent.src_b   = dp_src_b;
    dp_ent.funct7  = dp_funct7;
    dp_ent.funct3  = dp_funct3;
    dp_ent.spectag = dp_spectag;
    dp_ent.specbit = dp_specbit & ~(clear_spec & spec_hit(dp_spectag, spectagfix));
  end

  assign dp_kill  = prmiss & dp_specbit & spec_hit(dp_spectag, spectagfix);
  assign dp_write = dp_we & alloc_en & ~dp_kill;

  always_comb begin
    sel_ent = '0;
    if (sel_en) begin
      sel_ent = ent_q[sel_idx];
      if (clear_spec && spec_hit(sel_ent.spectag, spectagfix)) begin
        sel_ent.specbit = 1'b0;
      end
    end
  end

  assign ex_src1    = sel_ent.op1.val;
  assign ex_src2    = sel_ent.op2.val;
  assign ex_imm     = sel_ent.imm;
  assign ex_rrftag  = sel_ent.rrftag;
  assign ex_dstval  = sel_ent.dstval;
  assign ex_src_a   = sel_ent.src_a;
  assign ex_src_b   = sel_ent.src_b;
  assign ex_funct7  = sel_ent.funct7;
  assign ex_funct3  = sel_ent.funct3;
  assign ex_spectag = sel_ent.spectag;
  assign ex_specbit = sel_ent.specbit;

  // Allocation uses the pre-edge free list, so the issuing entry is never reused this cycle.
  always_comb begin
    busy_nx = busy;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ent_nx[i]     = ent_q[i];
      ent_nx[i].op1 = capture(ent_q[i].op1, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
      ent_nx[i].op2 = capture(ent_q[i].op2, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
      if (clear_spec && spec_hit(ent_q[i].spectag, spectagfix)) begin
        ent_nx[i].specbit = 1'b0;
      end
      if ((sel_en && (sel_idx == ENT_SEL'(i))) || kill[i]) begin
        busy_nx[i] = 1'b0;
      end
      if (dp_write && (alloc_idx == ENT_SEL'(i))) begin
        ent_nx[i]  = dp_ent;
        busy_nx[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      busy <= busy_nx;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= ent_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_custom.sv
// Self-checking bench for rs_custom: directed scenarios then randomized traffic,
// all compared against a behavioural list-of-instructions model.
module tb_rs_custom;
  import rs_custom_pkg::*;

  logic                       clk;
  logic                       reset;
  logic                       dp_we;
  logic [DATA_LEN-1:0]        dp_src1;
  logic                       dp_valid1;
  logic [DATA_LEN-1:0]        dp_src2;
  logic                       dp_valid2;
  logic [DATA_LEN-1:0]        dp_imm;
  logic [RRF_SEL-1:0]         dp_rrftag;
  logic                       dp_dstval;
  logic [SRC_A_SEL_WIDTH-1:0] dp_src_a;
  logic [SRC_B_SEL_WIDTH-1:0] dp_src_b;
  logic [FUNCT7_WIDTH-1:0]    dp_funct7;
  logic [FUNCT3_WIDTH-1:0]    dp_funct3;
  logic [SPECTAG_LEN-1:0]     dp_spectag;
  logic                       dp_specbit;
  logic                       wb0_en;
  logic [RRF_SEL-1:0]         wb0_tag;
  logic [DATA_LEN-1:0]        wb0_data;
  logic                       wb1_en;
  logic [RRF_SEL-1:0]         wb1_tag;
  logic [DATA_LEN-1:0]        wb1_data;
  logic                       prmiss;
  logic                       prsuccess;
  logic [SPECTAG_LEN-1:0]     spectagfix;
  logic                       rs_full;
  logic                       issue;
  logic [DATA_LEN-1:0]        ex_src1;
  logic [DATA_LEN-1:0]        ex_src2;
  logic [DATA_LEN-1:0]        ex_imm;
  logic [RRF_SEL-1:0]         ex_rrftag;
  logic                       ex_dstval;
  logic [SRC_A_SEL_WIDTH-1:0] ex_src_a;
  logic [SRC_B_SEL_WIDTH-1:0] ex_src_b;
  logic [FUNCT7_WIDTH-1:0]    ex_funct7;
  logic [FUNCT3_WIDTH-1:0]    ex_funct3;
  logic [SPECTAG_LEN-1:0]     ex_spectag;
  logic                       ex_specbit;

  rs_custom #(.ENTRIES(4), .ENT_SEL(2)) dut (
    .clk(clk), .reset(reset), .dp_we(dp_we),
    .dp_src1(dp_src1), .dp_valid1(dp_valid1), .dp_src2(dp_src2), .dp_valid2(dp_valid2),
    .dp_imm(dp_imm), .dp_rrftag(dp_rrftag), .dp_dstval(dp_dstval),
    .dp_src_a(dp_src_a), .dp_src_b(dp_src_b), .dp_funct7(dp_funct7), .dp_funct3(dp_funct3),
    .dp_spectag(dp_spectag), .dp_specbit(dp_specbit),
    .wb0_en(wb0_en), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix),
    .rs_full(rs_full), .issue(issue),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_rrftag(ex_rrftag),
    .ex_dstval(ex_dstval), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_funct7(ex_funct7), .ex_funct3(ex_funct3), .ex_spectag(ex_spectag),
    .ex_specbit(ex_specbit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one record per slot; an instruction lives in a slot until issued or killed.
  typedef struct {
    bit          busy;
    bit          v1;
    bit          v2;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] imm;
    logic [5:0]  tag;
    logic        dst;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  st;
    logic        spec;
  } m_ent_t;

  m_ent_t m [4];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_val(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] wake(logic v, logic [31:0] s);
    if (!v && wb0_en && wb0_tag == s[5:0]) return {1'b1, wb0_data};
    if (!v && wb1_en && wb1_tag == s[5:0]) return {1'b1, wb1_data};
    return {v, s};
  endfunction

  function automatic bit hits(logic [4:0] st);
    return (st & spectagfix) != 5'd0;
  endfunction

  // Compare the DUT against the model for the current inputs, then advance the model one edge.
  task automatic step(bit chk);
    int           sel;
    int           free;
    bit           kill [4];
    bit           clr;
    logic [122:0] exp_b;
    logic [122:0] obs_b;
    #1;
    clr  = prsuccess && !prmiss;
    sel  = -1;
    free = -1;
    for (int i = 0; i < 4; i++) begin
      kill[i] = prmiss && m[i].busy && m[i].spec && hits(m[i].st);
      if (!m[i].busy && free < 0) free = i;
      if (sel < 0 && m[i].busy && m[i].v1 && m[i].v2 && !kill[i]) sel = i;
    end
    exp_b = '0;
    if (sel >= 0)
      exp_b = {m[sel].s1, m[sel].s2, m[sel].imm, m[sel].tag, m[sel].dst, m[sel].sa,
               m[sel].sb, m[sel].f7, m[sel].f3, m[sel].st,
               m[sel].spec && !(clr && hits(m[sel].st))};
    obs_b = {ex_src1, ex_src2, ex_imm, ex_rrftag, ex_dstval, ex_src_a, ex_src_b,
             ex_funct7, ex_funct3, ex_spectag, ex_specbit};
    if (chk) begin
      check_val("rs_full", 128'(rs_full), 128'(free < 0));
      check_val("issue", 128'(issue), 128'(sel >= 0));
      check_val("ex_bundle", 128'(obs_b), 128'(exp_b));
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) m[i].busy = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!m[i].busy) continue;
        if (i == sel || kill[i]) begin
          m[i].busy = 0;
        end else begin
          {m[i].v1, m[i].s1} = wake(m[i].v1, m[i].s1);
          {m[i].v2, m[i].s2} = wake(m[i].v2, m[i].s2);
          if (clr && hits(m[i].st)) m[i].spec = 0;
        end
      end
      if (dp_we && free >= 0 && !(prmiss && dp_specbit && hits(dp_spectag))) begin
        m[free].busy = 1;
        {m[free].v1, m[free].s1} = wake(dp_valid1, dp_src1);
        {m[free].v2, m[free].s2} = wake(dp_valid2, dp_src2);
        m[free].imm  = dp_imm;
        m[free].tag  = dp_rrftag;
        m[free].dst  = dp_dstval;
        m[free].sa   = dp_src_a;
        m[free].sb   = dp_src_b;
        m[free].f7   = dp_funct7;
        m[free].f3   = dp_funct3;
        m[free].st   = dp_spectag;
        m[free].spec = dp_specbit && !(clr && hits(dp_spectag));
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset = 0; dp_we = 0; dp_src1 = '0; dp_valid1 = 0; dp_src2 = '0; dp_valid2 = 0;
    dp_imm = '0; dp_rrftag = '0; dp_dstval = 0; dp_src_a = '0; dp_src_b = '0;
    dp_funct7 = '0; dp_funct3 = '0; dp_spectag = '0; dp_specbit = 0;
    wb0_en = 0; wb0_tag = '0; wb0_data = '0; wb1_en = 0; wb1_tag = '0; wb1_data = '0;
    prmiss = 0; prsuccess = 0; spectagfix = '0;
  endtask

  task automatic dispatch_op(logic v1, logic [31:0] s1, logic v2, logic [31:0] s2,
                             logic [4:0] st, logic sp);
    dp_we = 1; dp_valid1 = v1; dp_src1 = s1; dp_valid2 = v2; dp_src2 = s2;
    dp_spectag = st; dp_specbit = sp;
    dp_imm = $urandom; dp_rrftag = 6'($urandom_range(0, 63)); dp_dstval = 1'($urandom_range(0, 1));
    dp_src_a = 2'($urandom_range(0, 3)); dp_src_b = 2'($urandom_range(0, 3));
    dp_funct7 = 7'($urandom_range(0, 127)); dp_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic randomize_inputs();
    dispatch_op(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)), 32'($urandom),
                5'(5'd1 << $urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    dp_we = ($urandom_range(0, 9) < 6);
    if (!dp_valid1) dp_src1 = 32'($urandom_range(0, 7));
    if (!dp_valid2) dp_src2 = 32'($urandom_range(0, 7));
    wb0_en = ($urandom_range(0, 9) < 4); wb0_tag = 6'($urandom_range(0, 7)); wb0_data = $urandom;
    wb1_en = ($urandom_range(0, 9) < 4); wb1_tag = 6'($urandom_range(0, 7)); wb1_data = $urandom;
    prmiss     = ($urandom_range(0, 15) == 0);
    prsuccess  = ($urandom_range(0, 9) == 0);
    spectagfix = 5'(5'd1 << $urandom_range(0, 4));
    reset      = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) m[i].busy = 0;
    clear_inputs();
    reset = 1;
    @(negedge clk);
    step(0);
    step(1);
    clear_inputs();
    #1;
    check_val("reset_full", 128'(rs_full), 128'(0));
    check_val("reset_issue", 128'(issue), 128'(0));

    // 1: both operands valid at dispatch
    dispatch_op(1, 32'd5, 1, 32'd7, 5'b00001, 0);
    step(1);
    clear_inputs(); #1;
    check_val("t1_issue", 128'(issue), 128'(1));
    check_val("t1_src1", 128'(ex_src1), 128'(5));
    check_val("t1_src2", 128'(ex_src2), 128'(7));
    step(1);
    #1;
    check_val("t1_freed", 128'(issue), 128'(0));

    // 2: operand arrives on wb0 two cycles after dispatch
    dispatch_op(0, 32'd12, 1, 32'd1, 5'b00001, 0);
    step(1);
    clear_inputs();
    step(1);
    wb0_en = 1; wb0_tag = 6'd12; wb0_data = 32'hABCD;
    step(1);
    clear_inputs(); #1;
    check_val("t2_issue", 128'(issue), 128'(1));
    check_val("t2_src1", 128'(ex_src1), 128'(32'hABCD));
    step(1);

    // 3: fill, ignored 5th dispatch, drain
    for (int t = 20; t < 24; t++) begin
      dispatch_op(0, 32'(t), 1, 32'd2, 5'b00001, 0);
      step(1);
    end
    clear_inputs(); #1;
    check_val("t3_full", 128'(rs_full), 128'(1));
    dispatch_op(1, 32'h55, 1, 32'h66, 5'b00001, 0);
    step(1);
    clear_inputs();
    wb0_en = 1; wb0_tag = 6'd20; wb0_data = 32'h2020;
    step(1);
    clear_inputs(); #1;
    check_val("t3_issue", 128'(issue), 128'(1));
    check_val("t3_src1", 128'(ex_src1), 128'(32'h2020));
    step(1);
    #1;
    check_val("t3_not_full", 128'(rs_full), 128'(0));
    wb0_en = 1; wb0_tag = 6'd21; wb0_data = 32'h2121;
    wb1_en = 1; wb1_tag = 6'd22; wb1_data = 32'h2222;
    step(1);
    clear_inputs();
    wb0_en = 1; wb0_tag = 6'd23; wb0_data = 32'h2323;
    step(1);
    clear_inputs();
    repeat (4) step(1);

    // 4: mispredict kills only the matching speculative entry
    dispatch_op(0, 32'd30, 1, 32'd3, 5'b00010, 1);
    step(1);
    dispatch_op(0, 32'd31, 1, 32'd3, 5'b00100, 1);
    step(1);
    clear_inputs();
    prmiss = 1; spectagfix = 5'b00010;
    step(1);
    clear_inputs();
    wb0_en = 1; wb0_tag = 6'd30; wb0_data = 32'h3030;
    wb1_en = 1; wb1_tag = 6'd31; wb1_data = 32'h3131;
    step(1);
    clear_inputs(); #1;
    check_val("t4_survivor", 128'(ex_src1), 128'(32'h3131));
    check_val("t4_spectag", 128'(ex_spectag), 128'(5'b00100));
    step(1);
    #1;
    check_val("t4_killed", 128'(issue), 128'(0));
    step(1);

    // 5: correct prediction clears specbit of a waiting entry
    dispatch_op(0, 32'd33, 1, 32'd4, 5'b00100, 1);
    step(1);
    clear_inputs();
    prsuccess = 1; spectagfix = 5'b00100;
    step(1);
    clear_inputs();
    wb0_en = 1; wb0_tag = 6'd33; wb0_data = 32'h5555;
    step(1);
    clear_inputs(); #1;
    check_val("t5_issue", 128'(issue), 128'(1));
    check_val("t5_specbit", 128'(ex_specbit), 128'(0));
    step(1);

    // 6: dispatch bypass from wb1
    dispatch_op(0, 32'd9, 1, 32'd8, 5'b00001, 0);
    wb1_en = 1; wb1_tag = 6'd9; wb1_data = 32'd3;
    step(1);
    clear_inputs(); #1;
    check_val("t6_issue", 128'(issue), 128'(1));
    check_val("t6_src1", 128'(ex_src1), 128'(3));
    step(1);

    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
